// File: rtl/flag_scan_ctrl_if.sv
// Handshake and result bundle for flag_scan_ctrl: the requester drives start/flags/ready,
// the scanner returns busy/valid and the captured word with its run statistics.
interface flag_scan_ctrl_if;
  logic        start;
  logic [15:0] flags_in;
  logic        out_ready;
  logic        busy;
  logic        out_valid;
  logic [15:0] word_out;
  logic [4:0]  pop_cnt;
  logic [4:0]  max_run;
  logic        corner;

  modport master (
    output start, flags_in, out_ready,
    input  busy, out_valid, word_out, pop_cnt, max_run, corner
  );

  modport slave (
    input  start, flags_in, out_ready,
    output busy, out_valid, word_out, pop_cnt, max_run, corner
  );
endinterface

// File: rtl/flag_scan_ctrl.sv
// Serial 16-lane flag scanner: popcount and longest set run, one lane per cycle.
// Define CIRC_RUN_EN to merge the trailing and leading runs across the lane 15 -> 0 wrap.
module flag_scan_ctrl #(
  parameter int unsigned RUN_THRESH = 9
) (
  input  logic             clk,
  input  logic             reset,
  flag_scan_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StScan, StFinal, StDone} state_e;

  localparam logic [4:0] ThreshW = 5'(RUN_THRESH);
  localparam logic [4:0] LaneMax = 5'd16;

  state_e      state_q, state_d;
  logic [15:0] word_q, word_d;
  logic [4:0]  pop_q, pop_d;
  logic [4:0]  max_q, max_d;
  logic [4:0]  cur_q, cur_d;
  logic [4:0]  lead_q, lead_d;
  logic        lead_open_q, lead_open_d;
  logic [3:0]  lane_q, lane_d;
  logic        bit_v;

  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v >= LaneMax) ? LaneMax : v + 5'd1;
  endfunction

`ifdef CIRC_RUN_EN
  logic [5:0] merge_sum;
  logic [4:0] merge_run;
  always_comb begin
    merge_sum = {1'b0, lead_q} + {1'b0, cur_q};
    merge_run = (merge_sum > 6'd16) ? LaneMax : merge_sum[4:0];
  end
`endif

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    pop_d       = pop_q;
    max_d       = max_q;
    cur_d       = cur_q;
    lead_d      = lead_q;
    lead_open_d = lead_open_q;
    lane_d      = lane_q;
    bit_v       = word_q[4'd15 - lane_q];

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          word_d      = bus.flags_in;
          pop_d       = '0;
          max_d       = '0;
          cur_d       = '0;
          lead_d      = '0;
          lead_open_d = 1'b1;
          lane_d      = '0;
          state_d     = StScan;
        end
      end
      StScan: begin
        if (bit_v) begin
          pop_d = sat_inc(pop_q);
          cur_d = sat_inc(cur_q);
          if (lead_open_q) lead_d = sat_inc(lead_q);
        end else begin
          cur_d       = '0;
          lead_open_d = 1'b0;
        end
        if (cur_d > max_q) max_d = cur_d;
        if (lane_q == 4'd15) begin
          lane_d  = '0;
          state_d = StFinal;
        end else begin
          lane_d = lane_q + 4'd1;
        end
      end
      StFinal: begin
`ifdef CIRC_RUN_EN
        // cur_q now holds the trailing run ending at lane 15
        if (merge_run > max_q) max_d = merge_run;
`else
        max_d = max_q;
`endif
        state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      word_q      <= '0;
      pop_q       <= '0;
      max_q       <= '0;
      cur_q       <= '0;
      lead_q      <= '0;
      lead_open_q <= 1'b0;
      lane_q      <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      pop_q       <= pop_d;
      max_q       <= max_d;
      cur_q       <= cur_d;
      lead_q      <= lead_d;
      lead_open_q <= lead_open_d;
      lane_q      <= lane_d;
    end
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.word_out  = word_q;
  assign bus.pop_cnt   = pop_q;
  assign bus.max_run   = max_q;
  assign bus.corner    = (max_q >= ThreshW);

endmodule

// File: tb/tb_flag_scan_ctrl.sv
// Randomized self-checking bench for flag_scan_ctrl against a lane-list reference model.
module tb_flag_scan_ctrl;
  localparam int unsigned Thresh = 9;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  flag_scan_ctrl_if bus();

  flag_scan_ctrl #(.RUN_THRESH(Thresh)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: lanes as a plain list, lane i = word bit (15 - i)
  function automatic void model(input logic [15:0] w, output int pop, output int mr);
    int lanes[16];
    int run;
    int total;
    pop = 0;
    mr  = 0;
    for (int i = 0; i < 16; i++) begin
      lanes[i] = int'(w[15 - i]);
      pop += lanes[i];
    end
`ifdef CIRC_RUN_EN
    total = 32;
`else
    total = 16;
`endif
    run = 0;
    for (int i = 0; i < total; i++) begin
      if (lanes[i % 16] == 1) run++;
      else run = 0;
      if (run > 16) run = 16;
      if (run > mr) mr = run;
    end
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
    else n_pass++;
  endtask

  // Start a scan and wait for out_valid; leaves the DUT in DONE.
  task automatic start_and_wait(input logic [15:0] w, output int cycles);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.flags_in = w;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.flags_in = $urandom();
    cycles = 0;
    while (bus.out_valid !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic run_one(input logic [15:0] w);
    int cyc, pop, mr;
    model(w, pop, mr);
    start_and_wait(w, cyc);
    check("latency", cyc, 17);
    check("word_out", int'(bus.word_out), int'(w));
    check("pop_cnt", int'(bus.pop_cnt), pop);
    check("max_run", int'(bus.max_run), mr);
    check("corner", int'(bus.corner), int'(mr >= int'(Thresh)));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("valid_after_xfer", int'(bus.out_valid), 0);
    check("busy_after_xfer", int'(bus.busy), 0);
    check("pop_retained", int'(bus.pop_cnt), pop);
    check("max_retained", int'(bus.max_run), mr);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #12;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_word", int'(bus.word_out), 0);
    check("rst_pop", int'(bus.pop_cnt), 0);
    check("rst_max", int'(bus.max_run), 0);
    check("rst_corner", int'(bus.corner), 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_directed;
    logic [15:0] vec [5];
    vec = '{16'h0000, 16'hFFFF, 16'hFF80, 16'hF01F, 16'h8001};
    foreach (vec[i]) run_one(vec[i]);
  endtask

  task automatic test_random;
    logic [15:0] w;
    for (int i = 0; i < 24; i++) begin
      w = 16'($urandom());
      if (i % 3 == 1) w = w | 16'($urandom());
      if (i % 3 == 2) w = w | 16'($urandom()) | 16'($urandom());
      run_one(w);
    end
  endtask

  task automatic test_backpressure;
    int cyc, pop, mr;
    logic [15:0] w;
    w = 16'hF01F;
    model(w, pop, mr);
    start_and_wait(w, cyc);
    check("bp_latency", cyc, 17);
    for (int i = 0; i < 5; i++) begin
      bus.start    = 1'b1;
      bus.flags_in = 16'h0F0F;
      @(negedge clk);
      check("bp_valid", int'(bus.out_valid), 1);
      check("bp_word", int'(bus.word_out), int'(w));
      check("bp_pop", int'(bus.pop_cnt), pop);
      check("bp_max", int'(bus.max_run), mr);
    end
    // start stays high through the transfer edge and must be ignored
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    check("bp_idle_valid", int'(bus.out_valid), 0);
    check("bp_idle_busy", int'(bus.busy), 0);
    check("bp_idle_word", int'(bus.word_out), int'(w));
    @(negedge clk);
    check("bp_no_restart", int'(bus.busy), 0);
  endtask

  task automatic test_reset_midscan;
    logic [15:0] w;
    w = 16'hFFFF;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.flags_in = w;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_busy_pre", int'(bus.busy), 1);
    #2 reset = 1'b0;
    #1;
    check("mid_busy", int'(bus.busy), 0);
    check("mid_word", int'(bus.word_out), 0);
    check("mid_pop", int'(bus.pop_cnt), 0);
    check("mid_max", int'(bus.max_run), 0);
    check("mid_corner", int'(bus.corner), 0);
    @(negedge clk);
    reset = 1'b1;
    run_one(16'h7FFE);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) run_one(16'($urandom()));
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    bus.start     = 1'b0;
    bus.flags_in  = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midscan();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/flag_scan_ctrl.md
FLAG_SCAN_CTRL -- requirements
Module: flag_scan_ctrl

Interface
REQ-001 SHALL have parameter RUN_THRESH, default 9, minimum contiguous set-lane count that flags a corner (legal 1..16).
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to capture flags_in and begin a scan.
REQ-005 SHALL have port flags_in, input, 16, packed lane flags; lane 0 in bit 15, lane 15 in bit 0.
REQ-006 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-007 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-008 SHALL have port out_valid, output, 1, result valid.
REQ-009 SHALL have port word_out, output, 16, captured flags word.
REQ-010 SHALL have port pop_cnt, output, 5, number of set lanes (0..16).
REQ-011 SHALL have port max_run, output, 5, longest run of contiguous set lanes (0..16).
REQ-012 SHALL have port corner, output, 1, max_run >= RUN_THRESH.

Function
REQ-013 SHALL implement states IDLE, SCAN, FINAL, DONE.
REQ-014 In IDLE, start=1 at an edge SHALL capture flags_in into word_out, clear counters, set lane index 0, go to SCAN.
REQ-015 start SHALL be ignored in SCAN, FINAL and DONE, including the cycle of a DONE transfer.
REQ-016 SCAN SHALL process one lane per cycle in order lane 0..15 (bit 15 down to bit 0); 16 cycles total, then FINAL.
REQ-017 Per lane: set bit increments pop_cnt and current run; clear bit resets current run to 0; max_run updated to max(max_run, current run).
REQ-018 SHALL record the leading run (set lanes from lane 0 up to first clear lane) during SCAN.
REQ-019 FINAL SHALL last exactly one cycle, apply the wrap merge when enabled (REQ-027), then go to DONE.
REQ-020 out_valid SHALL rise 17 cycles after the start-accepting edge and remain high only in DONE.
REQ-021 Transfer SHALL occur when out_valid and out_ready are both 1 at an edge; next state IDLE, out_valid 0.
REQ-022 word_out, pop_cnt, max_run, corner SHALL hold stable while out_valid=1 and retain their values in IDLE until the next accepted start.
REQ-023 corner SHALL be computed from the final max_run and be valid whenever out_valid=1.
REQ-024 Counters SHALL saturate at 16; no 5-bit wrap is permitted.

Reset
REQ-025 reset=0 SHALL immediately force state IDLE, busy 0, out_valid 0, word_out 0, pop_cnt 0, max_run 0, corner 0, lane index 0, all run counters 0, regardless of state, including mid-scan.
REQ-026 After reset is released, the first accepted start SHALL behave identically to a post-power-up start.

Configuration
REQ-027 With macro CIRC_RUN_EN defined, lanes SHALL be treated as a ring: in FINAL, max_run = max(max_run, min(trailing run + leading run, 16)); all-ones gives 16.
REQ-028 Without CIRC_RUN_EN, runs SHALL be linear (no merge across lane 15 -> lane 0); FINAL is still one cycle so latency is unchanged.

Verification
REQ-029 flags_in=16'h0000, start -> out_valid after 17 cycles; pop_cnt 0, max_run 0, corner 0.
REQ-030 flags_in=16'hFFFF -> pop_cnt 16, max_run 16, corner 1 (both configurations).
REQ-031 flags_in=16'hFF80 (lanes 0-8) -> pop_cnt 9, max_run 9, corner 1.
REQ-032 flags_in=16'hF01F -> pop_cnt 9; CIRC_RUN_EN: max_run 9, corner 1; without: max_run 5, corner 0.
REQ-033 Backpressure: out_ready=0 for 5 cycles in DONE with start pulses -> outputs unchanged, no restart; out_ready=1 -> IDLE next cycle, out_valid 0.
REQ-034 reset=0 asserted at lane index 7 -> all outputs 0 immediately; new start after release -> correct result for the new flags_in.
